memory_scan_reducer: RTL and testbench
======================================

MEMORY_SCAN_REDUCER -- requirements
Module: memory_scan_reducer

Interface
REQ-001 Parameter N, default 4: memory address width; depth = 2^N entries, N >= 1.
REQ-002 Parameter M, default 8: memory data width.
REQ-003 Parameter S, default 12: sum width, S >= M+N so a full-memory sum cannot overflow.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 reset  input  1: asynchronous, active-low reset.
REQ-006 start  input  1: scan request, pulse from a debounced button, sampled on rising clk.
REQ-007 readAddr1  output  N: address driven to memory read port 1.
REQ-008 readAddr2  output  N: address driven to memory read port 2.
REQ-009 readData1  input  M: memory read port 1 data, combinational from readAddr1, same-cycle valid.
REQ-010 readData2  input  M: memory read port 2 data, combinational from readAddr2, same-cycle valid.
REQ-011 sum  output  S: registered sum of all entries from the last completed scan.
REQ-012 maxValue  output  M: registered largest entry (unsigned) from the last completed scan.
REQ-013 busy  output  1: high while a scan is in progress.
REQ-014 done  output  1: one-cycle pulse on scan completion.

Function
REQ-015 FSM states SHALL be IDLE, SCAN, DONE; reset state IDLE.
REQ-016 IDLE: start=1 at a rising edge -> SCAN, pair index k <= 0, accumulator <= 0, running max <= 0; else stay IDLE.
REQ-017 SCAN, pair k: readAddr1 = 2k, readAddr2 = 2k+1, both combinational from k.
REQ-018 SCAN, each edge: accumulator += zero-extended readData1 + readData2; running max <= max(running max, readData1, readData2), unsigned.
REQ-019 SCAN: k increments each edge; on the edge where k = 2^(N-1)-1, go to DONE, and sum and maxValue load the final values including that last pair.
REQ-020 Latency: with default N, start accepted at edge E0, SCAN lasts 8 cycles, sum/maxValue update at edge E8, done high for the cycle after E8.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-022 busy SHALL be 1 exactly in SCAN; done SHALL be 1 exactly in DONE; never both high.
REQ-023 IDLE/DONE: readAddr1 = 0, readAddr2 = 1.
REQ-024 start in SCAN or DONE SHALL be ignored, with no queuing.
REQ-025 start held high SHALL produce back-to-back scans, one accepted per IDLE visit, i.e. every 2^(N-1)+2 cycles.
REQ-026 sum and maxValue SHALL hold their values between completions; partial results are never visible on them.
REQ-027 Memory writes during busy SHALL NOT be blocked by this block; the parent gates writes with busy, and results under concurrent writes are unspecified.
REQ-028 Accumulation SHALL be unsigned, modulo 2^S.

Reset
REQ-029 reset low SHALL immediately force IDLE, k=0, accumulator=0, running max=0, sum=0, maxValue=0, busy=0, done=0, readAddr1=0, readAddr2=1.
REQ-030 reset asserted mid-scan SHALL abort the scan without updating sum or maxValue beyond their reset value 0.
REQ-031 After reset release, the first start seen in IDLE SHALL begin a normal scan.

Verification
REQ-032 Scenario 1: all 16 entries 0x33, one start pulse -> busy for 8 cycles, done 1 cycle, sum=0x330, maxValue=0x33.
REQ-033 Scenario 2: all entries 0xFF -> sum=0xFF0 (no overflow), maxValue=0xFF.
REQ-034 Scenario 3: entry i = i for i = 0..15 -> sum=0x078, maxValue=0x0F, and readAddr pairs (0,1),(2,3)...(14,15) seen in order.
REQ-035 Scenario 4: second start pulse 3 cycles into a scan -> ignored, exactly one done, result unchanged from a single scan.
REQ-036 Scenario 5: reset pulled low during SCAN cycle 4 -> all outputs 0 asynchronously; a following start with entries 0x01 -> sum=0x010, maxValue=0x01.
REQ-037 Scenario 6: start held high for 25 cycles -> done pulses 10 cycles apart, busy low for exactly 2 cycles between scans.

Source files
------------

// File: rtl/memory_scan_reducer.sv
// Memory scan reducer: walks a dual-read-port memory two entries per cycle,
// accumulating the unsigned sum and tracking the largest entry, then
// publishes both results together on completion.
module memory_scan_reducer #(
  parameter int unsigned N = 4,   // memory address width, depth 2^N
  parameter int unsigned M = 8,   // memory data width
  parameter int unsigned S = 12   // sum width, S >= M + N
) (
  input  logic         clk,
  input  logic         reset,      // asynchronous, active low
  input  logic         start,
  output logic [N-1:0] readAddr1,
  output logic [N-1:0] readAddr2,
  input  logic [M-1:0] readData1,
  input  logic [M-1:0] readData2,
  output logic [S-1:0] sum,
  output logic [M-1:0] maxValue,
  output logic         busy,
  output logic         done
);

  // Pair index width; a 1-bit counter is kept even for the degenerate N = 1 case.
  localparam int unsigned KW = (N > 1) ? N - 1 : 1;
  localparam logic [KW-1:0] LastK = KW'((1 << (N - 1)) - 1);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [KW-1:0] r_k;
  logic [S-1:0]  r_acc;
  logic [M-1:0]  r_max;
  logic [S-1:0]  r_sum;
  logic [M-1:0]  r_max_value;

  logic          w_last_pair;
  logic          w_accept;
  logic [KW:0]   w_pair_base;
  logic [S-1:0]  w_acc_next;
  logic [M-1:0]  w_pair_max;
  logic [M-1:0]  w_max_next;

  assign w_last_pair = (r_state == StScan) && (r_k == LastK);
  assign w_accept    = (r_state == StIdle) && start;

  // Even address of the current pair; odd partner is the same with bit 0 set.
  assign w_pair_base = {r_k, 1'b0};
  assign readAddr1   = (r_state == StScan) ? w_pair_base[N-1:0] : '0;
  assign readAddr2   = (r_state == StScan) ? (w_pair_base[N-1:0] | N'(1)) : N'(1);

  // Running reductions including the pair currently on the read ports.
  assign w_acc_next = r_acc + S'(readData1) + S'(readData2);
  assign w_pair_max = (readData1 > readData2) ? readData1 : readData2;
  assign w_max_next = (w_pair_max > r_max) ? w_pair_max : r_max;

  assign sum      = r_sum;
  assign maxValue = r_max_value;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state and status outputs; start outside IDLE is dropped.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) w_state_next = StScan;
      end
      StScan: begin
        busy = 1'b1;
        if (r_k == LastK) w_state_next = StDone;
      end
      StDone: begin
        done         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Scan datapath; published results change only on the final pair.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k         <= '0;
      r_acc       <= '0;
      r_max       <= '0;
      r_sum       <= '0;
      r_max_value <= '0;
    end else if (w_accept) begin
      r_k   <= '0;
      r_acc <= '0;
      r_max <= '0;
    end else if (r_state == StScan) begin
      r_k   <= r_k + KW'(1);
      r_acc <= w_acc_next;
      r_max <= w_max_next;
      if (w_last_pair) begin
        r_sum       <= w_acc_next;
        r_max_value <= w_max_next;
      end
    end
  end

endmodule

// File: tb/tb_memory_scan_reducer.sv
// Self-checking bench for memory_scan_reducer: a 16x8 memory model feeds the
// read ports and results are compared against sums/maxima computed directly
// over the memory contents.
module tb_memory_scan_reducer;

  localparam int unsigned N = 4;
  localparam int unsigned M = 8;
  localparam int unsigned S = 12;
  localparam int Depth = 1 << N;
  localparam int ScanCycles = Depth / 2;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] readAddr1;
  logic [N-1:0] readAddr2;
  logic [M-1:0] readData1;
  logic [M-1:0] readData2;
  logic [S-1:0] sum;
  logic [M-1:0] maxValue;
  logic         busy;
  logic         done;

  logic [M-1:0] mem [Depth];

  int n_vec;
  int n_err;

  assign readData1 = mem[readAddr1];
  assign readData2 = mem[readAddr2];

  memory_scan_reducer #(.N(N), .M(M), .S(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .readAddr1 (readAddr1),
    .readAddr2 (readAddr2),
    .readData1 (readData1),
    .readData2 (readData2),
    .sum       (sum),
    .maxValue  (maxValue),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain reductions over the memory array.
  function automatic logic [S-1:0] ref_sum();
    int unsigned acc = 0;
    for (int i = 0; i < Depth; i++) acc += mem[i];
    return S'(acc);
  endfunction

  function automatic logic [M-1:0] ref_max();
    logic [M-1:0] mx = '0;
    for (int i = 0; i < Depth; i++) if (mem[i] > mx) mx = mem[i];
    return mx;
  endfunction

  task automatic fill_const(input logic [M-1:0] v);
    for (int i = 0; i < Depth; i++) mem[i] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one cycle, then watches until the block is idle again.
  // Stimulus/observation only; callers compare the returned observations.
  task automatic run_scan(output int nbusy, output int ndone, output int done_at,
                          output int addr_err, output int hold_err, output int both_err,
                          output bit timeout);
    logic [S-1:0] sum_before;
    logic [M-1:0] max_before;
    int pair;
    bit seen_done;
    nbusy = 0; ndone = 0; done_at = -1; addr_err = 0; hold_err = 0; both_err = 0;
    timeout = 1'b1;
    pair = 0;
    seen_done = 1'b0;
    sum_before = sum;
    max_before = maxValue;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (busy && done) both_err++;
      if (busy) begin
        nbusy++;
        if (readAddr1 !== N'(2 * pair) || readAddr2 !== N'(2 * pair + 1)) addr_err++;
        if (sum !== sum_before || maxValue !== max_before) hold_err++;
        pair++;
      end
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = c;
        seen_done = 1'b1;
      end
      if (seen_done && !busy && !done) begin
        timeout = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    fill_const('0);
    #3;
    n_vec++;
    if ({busy, done, sum, maxValue, readAddr1, readAddr2} !== {1'b0, 1'b0, S'(0), M'(0), N'(0), N'(1)}) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b sum=%h max=%h a1=%0d a2=%0d, want 0 0 000 00 0 1",
               busy, done, sum, maxValue, readAddr1, readAddr2);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: got busy=%0b done=%0b, want 0 0", busy, done);
    end
  endtask

  // Shared body for the deterministic-content scenarios.
  task automatic check_scan(input string name);
    int nbusy, ndone, done_at, addr_err, hold_err, both_err;
    bit timeout;
    logic [S-1:0] exp_sum;
    logic [M-1:0] exp_max;
    exp_sum = ref_sum();
    exp_max = ref_max();
    run_scan(nbusy, ndone, done_at, addr_err, hold_err, both_err, timeout);
    n_vec++;
    if (timeout) begin
      n_err++;
      $display("FAIL %s_timeout: got no completion within 40 cycles, want done", name);
    end
    n_vec++;
    if (nbusy != ScanCycles || ndone != 1 || done_at != ScanCycles) begin
      n_err++;
      $display("FAIL %s_timing: got busy=%0d done=%0d done_at=%0d, want %0d 1 %0d",
               name, nbusy, ndone, done_at, ScanCycles, ScanCycles);
    end
    n_vec++;
    if (sum !== exp_sum || maxValue !== exp_max) begin
      n_err++;
      $display("FAIL %s_result: got sum=%h max=%h, want sum=%h max=%h",
               name, sum, maxValue, exp_sum, exp_max);
    end
    n_vec++;
    if (addr_err != 0 || hold_err != 0 || both_err != 0) begin
      n_err++;
      $display("FAIL %s_sequence: got addr_err=%0d hold_err=%0d both_err=%0d, want 0 0 0",
               name, addr_err, hold_err, both_err);
    end
  endtask

  task automatic test_const_33();
    fill_const(8'h33);
    check_scan("const33");
    n_vec++;
    if (sum !== 12'h330 || maxValue !== 8'h33) begin
      n_err++;
      $display("FAIL const33_literal: got sum=%h max=%h, want 330 33", sum, maxValue);
    end
  endtask

  task automatic test_all_ff();
    fill_const(8'hFF);
    check_scan("allff");
    n_vec++;
    if (sum !== 12'hFF0 || maxValue !== 8'hFF) begin
      n_err++;
      $display("FAIL allff_literal: got sum=%h max=%h, want ff0 ff", sum, maxValue);
    end
  endtask

  task automatic test_ramp();
    for (int i = 0; i < Depth; i++) mem[i] = M'(i);
    check_scan("ramp");
    n_vec++;
    if (sum !== 12'h078 || maxValue !== 8'h0F) begin
      n_err++;
      $display("FAIL ramp_literal: got sum=%h max=%h, want 078 0f", sum, maxValue);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < Depth; i++) mem[i] = M'($urandom_range(0, 255));
      if (it == 5) mem[$urandom_range(0, Depth - 1)] = 8'hFF;
      check_scan($sformatf("random%0d", it));
    end
  endtask

  task automatic test_ignore_start();
    int ndone;
    bit busy_after;
    logic [S-1:0] exp_sum;
    logic [M-1:0] exp_max;
    for (int i = 0; i < Depth; i++) mem[i] = M'($urandom_range(1, 200));
    exp_sum = ref_sum();
    exp_max = ref_max();
    ndone = 0;
    busy_after = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done) ndone++;
      if (c > ScanCycles + 1 && busy) busy_after = 1'b1;
      start = (c == 3) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
    n_vec++;
    if (ndone != 1 || busy_after) begin
      n_err++;
      $display("FAIL ignore_start: got done_pulses=%0d rescan=%0b, want 1 0", ndone, busy_after);
    end
    n_vec++;
    if (sum !== exp_sum || maxValue !== exp_max) begin
      n_err++;
      $display("FAIL ignore_start_result: got sum=%h max=%h, want sum=%h max=%h",
               sum, maxValue, exp_sum, exp_max);
    end
  endtask

  task automatic test_reset_mid_scan();
    int nbusy, ndone, done_at, addr_err, hold_err, both_err;
    bit timeout;
    fill_const(8'h5A);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    // Fourth SCAN cycle: pull reset between clock edges.
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, sum, maxValue, readAddr1, readAddr2} !== {1'b0, 1'b0, S'(0), M'(0), N'(0), N'(1)}) begin
      n_err++;
      $display("FAIL midscan_reset: got busy=%0b done=%0b sum=%h max=%h a1=%0d a2=%0d, want 0 0 000 00 0 1",
               busy, done, sum, maxValue, readAddr1, readAddr2);
    end
    tick();
    reset = 1'b1;
    tick();
    tick();
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== S'(0)) begin
      n_err++;
      $display("FAIL midscan_aborted: got busy=%0b done=%0b sum=%h, want 0 0 000", busy, done, sum);
    end
    fill_const(8'h01);
    run_scan(nbusy, ndone, done_at, addr_err, hold_err, both_err, timeout);
    n_vec++;
    if (timeout || sum !== 12'h010 || maxValue !== 8'h01 || ndone != 1) begin
      n_err++;
      $display("FAIL post_reset_scan: got sum=%h max=%h done=%0d timeout=%0b, want 010 01 1 0",
               sum, maxValue, ndone, timeout);
    end
  endtask

  task automatic test_back_to_back();
    int done_idx[$];
    int gap_err, gaps, low_run;
    bit seen_busy, prev_busy, drained;
    gap_err = 0; gaps = 0; low_run = 0;
    seen_busy = 1'b0; prev_busy = 1'b0; drained = 1'b0;
    for (int i = 0; i < Depth; i++) mem[i] = M'($urandom_range(0, 255));
    start = 1'b1;
    tick();
    for (int c = 0; c < 60; c++) begin
      if (c == 24) start = 1'b0;
      if (done) done_idx.push_back(c);
      if (busy) begin
        if (seen_busy && !prev_busy) begin
          gaps++;
          if (low_run != 2) gap_err++;
        end
        seen_busy = 1'b1;
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_busy = busy;
      if (c > 24 && !busy && !done) begin
        drained = 1'b1;
        break;
      end
      tick();
    end
    start = 1'b0;
    n_vec++;
    if (!drained || done_idx.size() != 3) begin
      n_err++;
      $display("FAIL b2b_count: got done_pulses=%0d drained=%0b, want 3 1", done_idx.size(), drained);
    end
    for (int i = 1; i < done_idx.size(); i++) begin
      n_vec++;
      if (done_idx[i] - done_idx[i-1] != ScanCycles + 2) begin
        n_err++;
        $display("FAIL b2b_spacing%0d: got %0d cycles, want %0d",
                 i, done_idx[i] - done_idx[i-1], ScanCycles + 2);
      end
    end
    n_vec++;
    if (gaps != 2 || gap_err != 0) begin
      n_err++;
      $display("FAIL b2b_busy_gap: got gaps=%0d bad=%0d, want 2 0", gaps, gap_err);
    end
    n_vec++;
    if (sum !== ref_sum() || maxValue !== ref_max()) begin
      n_err++;
      $display("FAIL b2b_result: got sum=%h max=%h, want sum=%h max=%h",
               sum, maxValue, ref_sum(), ref_max());
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_const_33();
    test_all_ff();
    test_ramp();
    test_random();
    test_ignore_start();
    test_reset_mid_scan();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
